// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, issues one sequential fetch per cycle to a 1-cycle
// latency instruction memory and buffers {pc, instr} pairs for decode.
module if_fetch_queue #(
   parameter int unsigned       AWIDTH       = 32,
   parameter int unsigned       DWIDTH       = 32,
   parameter logic [AWIDTH-1:0] RESET_PC_VAL = '0,
   parameter int unsigned       DEPTH        = 4,
   parameter int unsigned       STEP         = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_pc,
   output logic              imem_en,
   output logic [AWIDTH-1:0] imem_addr,
   input  logic [DWIDTH-1:0] imem_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AWIDTH-1:0] out_pc,
   output logic [DWIDTH-1:0] out_instr,
   output logic [AWIDTH-1:0] pc_val
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 2;

   logic [AWIDTH-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [AWIDTH-1:0] pc_mem_q    [DEPTH];
   logic [DWIDTH-1:0] instr_mem_q [DEPTH];

   logic              push;
   logic              pop;
   logic              space;
   logic [CNT_W-1:0]  occupancy;

   // Handshake, issue decision and next-state; redirect overrides everything
   always_comb begin
      out_valid = (count_q != '0) && !redirect;
      pop       = out_valid && out_ready;
      push      = inflight_q && !redirect;
      occupancy = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
      space     = occupancy < CNT_W'(DEPTH);
      imem_en   = !rst && (redirect || space);
      imem_addr = redirect ? redirect_pc : pc_q;

      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (redirect) begin
         pc_d          = redirect_pc + AWIDTH'(STEP);
         inflight_d    = 1'b1;
         inflight_pc_d = redirect_pc;
         rd_ptr_d      = wr_ptr_q;
         count_d       = '0;
      end else begin
         if (space) begin
            pc_d          = pc_q + AWIDTH'(STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC_VAL;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC_VAL;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: only entries covered by count_q are ever presented
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_dout;
      end
   end

   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign pc_val    = pc_q;

   // The space check must make a push into a full, non-draining FIFO impossible
   assert property (@(posedge clk) disable iff (rst)
                    !(push && (count_q == CNT_W'(DEPTH)) && !pop))
      else $error("if_fetch_queue: push into full FIFO");

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: sequential fetch, backpressure, redirects,
// PC wrap and asynchronous reset, with a 1-cycle latency memory model.
module tb_if_fetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] pc_val;

   int tests;
   int fails;

   if_fetch_queue #(
      .AWIDTH(32), .DWIDTH(32), .RESET_PC_VAL(32'h0), .DEPTH(4), .STEP(4)
   ) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .pc_val(pc_val)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] imem_data(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Synchronous instruction memory, data one cycle after the request
   always @(posedge clk) begin
      if (imem_en) imem_dout <= imem_data(imem_addr);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic ready);
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      out_ready = ready;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      out_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (imem_en !== 1'b0) begin
         fails++; $display("FAIL reset_imem_en got=%b want=0", imem_en);
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      tests++;
      if (pc_val !== 32'h0) begin
         fails++; $display("FAIL reset_pc_val got=%h want=00000000", pc_val);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp;
      apply_reset(1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         exp = 32'(4 * i);
         tests++;
         if (imem_en !== 1'b1 || imem_addr !== exp) begin
            fails++;
            $display("FAIL seq_issue[%0d] en=%b addr=%h want en=1 addr=%h", i, imem_en, imem_addr, exp);
         end
         tests++;
         if (out_valid !== 1'(i >= 2)) begin
            fails++;
            $display("FAIL seq_valid[%0d] got=%b want=%b", i, out_valid, 1'(i >= 2));
         end
         if (i >= 2) begin
            tests++;
            if (out_pc !== exp - 32'd8 || out_instr !== imem_data(exp - 32'd8)) begin
               fails++;
               $display("FAIL seq_out[%0d] pc=%h instr=%h want pc=%h instr=%h", i, out_pc, out_instr, exp - 32'd8, imem_data(exp - 32'd8));
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_issue;
      logic [31:0] exp_out;
      apply_reset(1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests++;
         if (i < 4) begin
            if (imem_en !== 1'b1 || imem_addr !== 32'(4 * i)) begin
               fails++;
               $display("FAIL bp_issue[%0d] en=%b addr=%h want en=1 addr=%h", i, imem_en, imem_addr, 32'(4 * i));
            end
         end else begin
            if (imem_en !== 1'b0 || pc_val !== 32'h10) begin
               fails++;
               $display("FAIL bp_stall[%0d] en=%b pc_val=%h want en=0 pc_val=00000010", i, imem_en, pc_val);
            end
         end
         if (i >= 2) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
               fails++;
               $display("FAIL bp_head[%0d] valid=%b pc=%h want valid=1 pc=00000000", i, out_valid, out_pc);
            end
         end
         next_cycle();
      end
      out_ready = 1'b1;
      exp_issue = 32'h10;
      exp_out = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_en) begin
            tests++;
            if (imem_addr !== exp_issue) begin
               fails++;
               $display("FAIL bp_resume_addr got=%h want=%h", imem_addr, exp_issue);
            end
            exp_issue += 32'd4;
         end
         if (out_valid) begin
            tests++;
            if (out_pc !== exp_out || out_instr !== imem_data(exp_out)) begin
               fails++;
               $display("FAIL bp_drain pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, exp_out, imem_data(exp_out));
            end
            exp_out += 32'd4;
         end
         next_cycle();
      end
      tests++;
      if (exp_out !== 32'h28 || exp_issue !== 32'h38) begin
         fails++;
         $display("FAIL bp_totals out_next=%h issue_next=%h want out_next=00000028 issue_next=00000038", exp_out, exp_issue);
      end
   endtask

   task automatic test_redirect_flush();
      logic [31:0] exp;
      apply_reset(1'b0);
      for (int i = 0; i < 4; i++) next_cycle();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'h100) begin
         fails++;
         $display("FAIL redir_cycle valid=%b en=%b addr=%h want valid=0 en=1 addr=00000100", out_valid, imem_en, imem_addr);
      end
      next_cycle();
      redirect = 1'b0;
      out_ready = 1'b1;
      exp = 32'h100;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) begin
            tests++;
            if (out_pc !== exp || out_instr !== imem_data(exp)) begin
               fails++;
               $display("FAIL redir_out pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, exp, imem_data(exp));
            end
            if (out_ready) exp += 32'd4;
         end
         next_cycle();
      end
      tests++;
      if (exp !== 32'h11C) begin
         fails++; $display("FAIL redir_count next=%h want=0000011c", exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      redirect = 1'b1;
      redirect_pc = 32'h200;
      next_cycle();
      redirect_pc = 32'h300;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h300) begin
         fails++;
         $display("FAIL b2b_second valid=%b addr=%h want valid=0 addr=00000300", out_valid, imem_addr);
      end
      next_cycle();
      redirect = 1'b0;
      exp = 32'h300;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) begin
            tests++;
            if (out_pc !== exp) begin
               fails++; $display("FAIL b2b_out pc=%h want=%h", out_pc, exp);
            end
            if (out_ready) exp += 32'd4;
         end
         next_cycle();
      end
      tests++;
      if (exp !== 32'h31C) begin
         fails++; $display("FAIL b2b_count next=%h want=0000031c", exp);
      end
   endtask

   task automatic test_redirect_with_pop();
      logic [31:0] exp;
      apply_reset(1'b0);
      for (int i = 0; i < 3; i++) next_cycle();
      redirect = 1'b1;
      redirect_pc = 32'h400;
      out_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL rpop_valid got=%b want=0", out_valid);
      end
      next_cycle();
      redirect = 1'b0;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL rpop_empty got=%b want=0", out_valid);
      end
      exp = 32'h400;
      for (int c = 0; c < 22; c++) begin
         if (c == 7)  out_ready = 1'b0;
         if (c == 13) out_ready = 1'b1;
         if (c > 0) @(negedge clk);
         if (out_valid) begin
            tests++;
            if (out_pc !== exp || out_instr !== imem_data(exp)) begin
               fails++;
               $display("FAIL rpop_out pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, exp, imem_data(exp));
            end
            if (out_ready) exp += 32'd4;
         end
         next_cycle();
      end
      tests++;
      if (exp !== 32'h43C) begin
         fails++; $display("FAIL rpop_count next=%h want=0000043c", exp);
      end
   endtask

   task automatic test_wrap_and_async_reset();
      logic [31:0] exp;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      tests++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         fails++; $display("FAIL wrap_redir_addr got=%h want=fffffffc", imem_addr);
      end
      next_cycle();
      redirect = 1'b0;
      exp = 32'hFFFF_FFFC;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            tests++;
            if (imem_addr !== 32'h0) begin
               fails++; $display("FAIL wrap_issue got=%h want=00000000", imem_addr);
            end
         end
         if (out_valid) begin
            tests++;
            if (out_pc !== exp) begin
               fails++; $display("FAIL wrap_out pc=%h want=%h", out_pc, exp);
            end
            exp += 32'd4;
         end
         next_cycle();
      end
      tests++;
      if (exp !== 32'h10) begin
         fails++; $display("FAIL wrap_count next=%h want=00000010", exp);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1) begin
         fails++; $display("FAIL arst_pre_valid got=%b want=1", out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || imem_en !== 1'b0 || pc_val !== 32'h0) begin
         fails++;
         $display("FAIL arst_clear valid=%b en=%b pc_val=%h want valid=0 en=0 pc_val=00000000", out_valid, imem_en, pc_val);
      end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            tests++;
            if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin
               fails++; $display("FAIL arst_refetch en=%b addr=%h want en=1 addr=00000000", imem_en, imem_addr);
            end
         end
         if (c == 1) begin
            tests++;
            if (out_valid !== 1'b0) begin
               fails++; $display("FAIL arst_stale valid=%b pc=%h want valid=0", out_valid, out_pc);
            end
         end
         if (c == 2) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== imem_data(32'h0)) begin
               fails++;
               $display("FAIL arst_first valid=%b pc=%h instr=%h want valid=1 pc=00000000 instr=%h", out_valid, out_pc, out_instr, imem_data(32'h0));
            end
         end
         next_cycle();
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      out_ready = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_flush();
      test_back_to_back();
      test_redirect_with_pop();
      test_wrap_and_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
